// File: rtl/ysyx_23060208_scoreboard.sv
// Hazard scoreboard for IDU->EXU issue: counts in-flight GPR/CSR writes and
// raises stall while a decoded instruction's sources (or a saturated destination) are pending.
module ysyx_23060208_scoreboard #(
    parameter int REG_WIDTH = 5,
    parameter int CNT_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_WIDTH-1:0]      dec_rs1,
    input  logic [REG_WIDTH-1:0]      dec_rs2,
    input  logic                      dec_rs1_used,
    input  logic                      dec_rs2_used,
    input  logic [REG_WIDTH-1:0]      dec_rd,
    input  logic                      dec_rd_wen,
    input  logic                      dec_csr_read,
    input  logic                      dec_csr_wen,
    input  logic                      issue_valid,
    input  logic                      wb_wen,
    input  logic [REG_WIDTH-1:0]      wb_waddr,
    input  logic                      wb_csr_wen,
    input  logic                      flush,
    output logic                      stall,
    output logic [(1<<REG_WIDTH)-1:0] busy_mask,
    output logic                      csr_busy,
    output logic                      err
);
    localparam int NREG = 1 << REG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] cnt     [NREG];
    logic [CNT_WIDTH-1:0] cnt_nxt [NREG];
    logic [CNT_WIDTH-1:0] csr_cnt;
    logic [CNT_WIDTH-1:0] csr_cnt_nxt;
    logic                 raw1, raw2, rawc, full, iss, underflow;
    logic                 inc, dec, csr_inc, csr_dec;

    // Handshake: the IDU presents issue_valid only as the EXU accepts; the
    // transfer is recorded only when stall is low in that same cycle.
    always_comb begin
        raw1  = dec_rs1_used && (dec_rs1 != '0) && (cnt[dec_rs1] != '0);
        raw2  = dec_rs2_used && (dec_rs2 != '0) && (cnt[dec_rs2] != '0);
        rawc  = dec_csr_read && (csr_cnt != '0);
        full  = (dec_rd_wen && (dec_rd != '0) && (cnt[dec_rd] == CNT_MAX)) ||
                (dec_csr_wen && (csr_cnt == CNT_MAX));
        stall = raw1 | raw2 | rawc | full;
        iss   = issue_valid && !stall;
    end

    always_comb begin
        underflow  = 1'b0;
        inc        = 1'b0;
        dec        = 1'b0;
        cnt_nxt[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            inc        = iss && dec_rd_wen && (dec_rd == REG_WIDTH'(i));
            dec        = wb_wen && (wb_waddr == REG_WIDTH'(i));
            cnt_nxt[i] = cnt[i];
            if (inc && !dec) begin
                cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
            end else if (dec && !inc) begin
                if (cnt[i] == '0) underflow = 1'b1;
                else              cnt_nxt[i] = cnt[i] - CNT_WIDTH'(1);
            end
        end
        csr_inc     = iss && dec_csr_wen;
        csr_dec     = wb_csr_wen;
        csr_cnt_nxt = csr_cnt;
        if (csr_inc && !csr_dec) begin
            csr_cnt_nxt = csr_cnt + CNT_WIDTH'(1);
        end else if (csr_dec && !csr_inc) begin
            if (csr_cnt == '0) underflow = 1'b1;
            else               csr_cnt_nxt = csr_cnt - CNT_WIDTH'(1);
        end
    end

    // Flush clears tracking but leaves the sticky error untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
            csr_cnt <= '0;
            err     <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) cnt[i] <= flush ? '0 : cnt_nxt[i];
            csr_cnt <= flush ? '0 : csr_cnt_nxt;
            err     <= err | underflow;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < NREG; i++) busy_mask[i] = (cnt[i] != '0);
        csr_busy = (csr_cnt != '0);
    end
endmodule

// File: tb/tb_ysyx_23060208_scoreboard.sv
// Directed table-driven bench for the scoreboard: each record drives one cycle,
// checks stall before the edge and busy/csr_busy/err after it.
module tb_ysyx_23060208_scoreboard;
    logic        clk;
    logic        rst;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_waddr;
    logic        dec_rs1_used, dec_rs2_used, dec_rd_wen, dec_csr_read, dec_csr_wen;
    logic        issue_valid, wb_wen, wb_csr_wen, flush;
    logic        stall, csr_busy, err;
    logic [31:0] busy_mask;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       rdw, cr, cw, iss, wbw;
        logic [4:0] wa;
        logic       wbc, fl, rs;
        logic       e_stall;
        logic [31:0] e_busy;
        logic       e_csr;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    ysyx_23060208_scoreboard dut (
        .clk(clk), .rst(rst),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .dec_rd(dec_rd), .dec_rd_wen(dec_rd_wen),
        .dec_csr_read(dec_csr_read), .dec_csr_wen(dec_csr_wen),
        .issue_valid(issue_valid), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
        .wb_csr_wen(wb_csr_wen), .flush(flush),
        .stall(stall), .busy_mask(busy_mask), .csr_busy(csr_busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic [4:0] rd, logic rdw, logic cr, logic cw, logic iss,
                                logic wbw, logic [4:0] wa, logic wbc, logic fl, logic rs,
                                logic e_stall, logic [31:0] e_busy, logic e_csr, logic e_err);
        vec_t v;
        v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.rdw = rdw; v.cr = cr; v.cw = cw; v.iss = iss;
        v.wbw = wbw; v.wa = wa; v.wbc = wbc; v.fl = fl; v.rs = rs;
        v.e_stall = e_stall; v.e_busy = e_busy; v.e_csr = e_csr; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic apply_vec(vec_t v);
        logic [31:0] eb;
        @(negedge clk);
        dec_rs1 = v.rs1; dec_rs2 = v.rs2; dec_rs1_used = v.u1; dec_rs2_used = v.u2;
        dec_rd = v.rd; dec_rd_wen = v.rdw; dec_csr_read = v.cr; dec_csr_wen = v.cw;
        issue_valid = v.iss; wb_wen = v.wbw; wb_waddr = v.wa; wb_csr_wen = v.wbc;
        flush = v.fl; rst = v.rs;
        exp_q.push_back(v.e_busy);
        #1;
        check({v.name, ".stall"}, 32'(stall), 32'(v.e_stall));
        @(posedge clk);
        #1;
        eb = exp_q.pop_front();
        check({v.name, ".busy_mask"}, busy_mask, eb);
        check({v.name, ".csr_busy"}, 32'(csr_busy), 32'(v.e_csr));
        check({v.name, ".err"}, 32'(err), 32'(v.e_err));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; wb_wen = 1'b0; wb_csr_wen = 1'b0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;
        dec_rd = '0; dec_rd_wen = 1'b0; dec_csr_read = 1'b0; dec_csr_wen = 1'b0; wb_waddr = '0;
        repeat (2) @(posedge clk);

        //            name              rs1 rs2 u1 u2 rd rdw cr cw iss wbw wa wbc fl rs  stall busy          csr err
        vecs.push_back(mk("reset_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mk("addi_x5",      0, 0, 0, 0, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h20,       0, 0));
        vecs.push_back(mk("add_x6_stall", 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20,       0, 0));
        vecs.push_back(mk("wb_x5_nobyp",  5, 5, 1, 1, 6, 1, 0, 0, 0, 1, 5, 0, 0, 0, 1, 32'h0,        0, 0));
        vecs.push_back(mk("add_x6_go",    5, 5, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h40,       0, 0));
        vecs.push_back(mk("wb_x6",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mk("x7_w1",        0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h80,       0, 0));
        vecs.push_back(mk("x7_w2",        0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h80,       0, 0));
        vecs.push_back(mk("x7_w3",        0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h80,       0, 0));
        vecs.push_back(mk("x7_full_ign",  0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h80,       0, 0));
        vecs.push_back(mk("x7_full_wb",   0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 7, 0, 0, 0, 1, 32'h80,       0, 0));
        vecs.push_back(mk("x7_room",      0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80,       0, 0));
        vecs.push_back(mk("x7_wb_a",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 32'h80,       0, 0));
        vecs.push_back(mk("x7_wb_b",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mk("x9_issue",     0, 0, 0, 0, 9, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h200,      0, 0));
        vecs.push_back(mk("x9_iss_wb",    0, 0, 0, 0, 9, 1, 0, 0, 1, 1, 9, 0, 0, 0, 0, 32'h200,      0, 0));
        vecs.push_back(mk("x9_wb",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mk("x0_iss_wb",    0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mk("x0_reader",    0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mk("csrrw",        0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,        1, 0));
        vecs.push_back(mk("mret_stall",   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        1, 0));
        vecs.push_back(mk("mret_csr_wb",  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0,        0, 0));
        vecs.push_back(mk("mret_go",      0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mk("x3_underflow", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 32'h0,        0, 1));
        vecs.push_back(mk("busy_x4",      0, 0, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h10,       0, 1));
        vecs.push_back(mk("rs2_only",     0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10,       0, 1));
        vecs.push_back(mk("rs_unused",    4, 4, 0, 0, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h30,       0, 1));
        vecs.push_back(mk("flush_iss",    0, 0, 0, 0, 6, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 32'h0,        0, 1));
        vecs.push_back(mk("busy_x8",      0, 0, 0, 0, 8, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h100,      0, 1));
        vecs.push_back(mk("rst_mid",      0, 0, 0, 0, 2, 1, 0, 0, 1, 1, 3, 0, 1, 1, 0, 32'h0,        0, 0));

        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

        // CSR counter saturation, flush of CSR tracking, then CSR underflow.
        apply_vec(mk("csr_w1",      0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0));
        apply_vec(mk("csr_w2",      0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0));
        apply_vec(mk("csr_w3",      0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0));
        apply_vec(mk("csr_full",    0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0));
        apply_vec(mk("csr_flush",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 32'h0, 0, 0));
        apply_vec(mk("csr_undflow", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 1));

        // Hazard on an arbitrary register picked at run time.
        begin
            logic [4:0] r;
            r = 5'($urandom_range(1, 31));
            apply_vec(mk("rnd_issue", 0, 0, 0, 0, r, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h1 << r, 0, 1));
            apply_vec(mk("rnd_raw",   r, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1 << r, 0, 1));
            apply_vec(mk("rnd_wb",    r, 0, 1, 0, 0, 0, 0, 0, 0, 1, r, 0, 0, 0, 1, 32'h0,      0, 1));
            apply_vec(mk("rnd_clear", r, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,      0, 1));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
